mvm_inst_sequencer: RTL and testbench

//  Turns one job descriptor into the MVM instruction stream: one instruction packet per weight row,

---
 rtl/mvm_pkg.sv | 41 ++++
 rtl/mvm_inst_encode.sv | 67 ++++++
 rtl/mvm_inst_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_mvm_inst_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for logic that talks to an rtl_mvm tile:
//   - bit offsets of the fields in a 32-bit MVM instruction word
//   - tuser layout and op encodings of the MVM AXIS rx port
//   - state type of the instruction sequencer
// No ports; imported with "import mvm_pkg::*;".
// -----------------------------------------------------------------------------
package mvm_pkg;

    // Instruction word layout (low 32 bits of tdata; everything above is zero).
    localparam int INST_RDC        = 0;
    localparam int INST_ACM_EN     = 1;
    localparam int INST_RLS        = 2;
    localparam int INST_LST        = 3;
    localparam int INST_ACCUM_OFS  = 4;
    localparam int INST_RFADDR_OFS = 13;
    localparam int INST_DEST_OFS   = 22;
    localparam int INST_RLS_OP     = 31;
    localparam int INST_WORDW      = 32;

    // tuser layout: [8:0] addr, [10:9] op, [74:11] mask.
    localparam int TUSER_ADDR_OFS  = 0;
    localparam int TUSER_OP_OFS    = 9;
    localparam int TUSER_MASK_OFS  = 11;

    // tuser op encodings.
    localparam logic [1:0] OP_RF   = 2'b11;
    localparam logic [1:0] OP_IVEC = 2'b10;
    localparam logic [1:0] OP_RVEC = 2'b01;
    localparam logic [1:0] OP_INST = 2'b00;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/mvm_inst_encode.sv
// -----------------------------------------------------------------------------
// mvm_inst_encode
// Combinational packer: job descriptor fields plus a row index -> one MVM
// instruction beat (tdata/tuser/tlast). Kept separate so other loaders can
// build instruction words the same way.
// Ports:
//   rdc         in   1        reduction enable copied into every row
//   accum_addr  in   RFADDRW  accumulator address
//   rf_base     in   RFADDRW  RF address of row 0
//   dest        in   NODESW   release destination
//   rls_op      in   1        release op bit
//   rows        in   ROWW     total rows in the job
//   row         in   ROWW     index of the row being encoded
//   tdata       out  DATAW    instruction beat data
//   tuser       out  USERW    instruction beat sideband (op = INST)
//   tlast       out  1        always 1: every instruction is a single beat
// -----------------------------------------------------------------------------
module mvm_inst_encode
    import mvm_pkg::*;
#(
    parameter int DATAW   = 512,
    parameter int USERW   = 75,
    parameter int RFADDRW = 9,
    parameter int NODESW  = 9,
    parameter int ROWW    = 9
)
(
    input  logic               rdc,
    input  logic [RFADDRW-1:0] accum_addr,
    input  logic [RFADDRW-1:0] rf_base,
    input  logic [NODESW-1:0]  dest,
    input  logic               rls_op,
    input  logic [ROWW-1:0]    rows,
    input  logic [ROWW-1:0]    row,
    output logic [DATAW-1:0]   tdata,
    output logic [USERW-1:0]   tuser,
    output logic               tlast
);

    logic               is_last;
    logic [RFADDRW-1:0] rf_addr;

    // The last row carries both release and last flags; the RF address
    // wraps modulo 2**RFADDRW without any indication.
    assign is_last = (row == rows - ROWW'(1));
    assign rf_addr = rf_base + RFADDRW'(row);

    // Build the beat from zero so unused tdata/tuser bits stay cleared.
    // Row 0 starts a fresh accumulation; every later row accumulates.
    always_comb begin
        tdata = '0;
        tdata[INST_RDC]                    = rdc;
        tdata[INST_ACM_EN]                 = (row != '0);
        tdata[INST_RLS]                    = is_last;
        tdata[INST_LST]                    = is_last;
        tdata[INST_ACCUM_OFS +: RFADDRW]   = accum_addr;
        tdata[INST_RFADDR_OFS +: RFADDRW]  = rf_addr;
        tdata[INST_DEST_OFS +: NODESW]     = dest;
        tdata[INST_RLS_OP]                 = rls_op;

        tuser = '0;
        tuser[TUSER_OP_OFS +: 2] = OP_INST;

        tlast = 1'b1;
    end

endmodule

// File: rtl/mvm_inst_sequencer.sv
// -----------------------------------------------------------------------------
// mvm_inst_sequencer
// Accepts one job descriptor, streams one single-beat instruction per weight
// row into an rtl_mvm rx port, waits for the released result on the MVM tx
// handshake, then pulses done (with err) for one cycle.
// Optional feature: define MVM_SEQ_TIMEOUT_EN to add a TOW-bit watchdog on
// the result wait; without it the sequencer waits indefinitely.
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   job_valid/job_ready                  descriptor handshake
//   job_rf_base, job_rows, job_accum_addr,
//   job_dest, job_rls_op, job_rdc        descriptor fields (latched on accept)
//   m_tvalid/m_tdata/m_tuser/m_tlast     instruction stream to MVM axis_rx
//   m_tready                             from MVM axis_rx_tready
//   res_fire                             MVM axis_tx_tvalid & axis_tx_tready
//   busy                                 job in progress
//   done, err                            one-cycle completion pulse and error
// -----------------------------------------------------------------------------
module mvm_inst_sequencer
    import mvm_pkg::*;
#(
    parameter int DATAW   = 512,
    parameter int USERW   = 75,
    parameter int RFADDRW = 9,
    parameter int NODESW  = 9,
    parameter int ROWW    = 9
`ifdef MVM_SEQ_TIMEOUT_EN
    ,
    parameter int TOW     = 16
`endif
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [RFADDRW-1:0] job_rf_base,
    input  logic [ROWW-1:0]    job_rows,
    input  logic [RFADDRW-1:0] job_accum_addr,
    input  logic [NODESW-1:0]  job_dest,
    input  logic               job_rls_op,
    input  logic               job_rdc,
    output logic               m_tvalid,
    output logic [DATAW-1:0]   m_tdata,
    output logic [USERW-1:0]   m_tuser,
    output logic               m_tlast,
    input  logic               m_tready,
    input  logic               res_fire,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seq_state_t state;
    seq_state_t state_next;

    logic [RFADDRW-1:0] rf_base_r;
    logic [RFADDRW-1:0] accum_r;
    logic [NODESW-1:0]  dest_r;
    logic [ROWW-1:0]    rows_r;
    logic [ROWW-1:0]    row_r;
    logic               rls_op_r;
    logic               rdc_r;
    logic               err_r;

    logic               beat_fire;
    logic               last_beat;
    logic               to_expired;

    logic [DATAW-1:0]   enc_tdata;
    logic [USERW-1:0]   enc_tuser;
    logic               enc_tlast;

    assign beat_fire = (state == ISSUE) && m_tready;
    assign last_beat = (row_r == rows_r - ROWW'(1));

    mvm_inst_encode #(
        .DATAW   (DATAW),
        .USERW   (USERW),
        .RFADDRW (RFADDRW),
        .NODESW  (NODESW),
        .ROWW    (ROWW)
    ) u_encode (
        .rdc        (rdc_r),
        .accum_addr (accum_r),
        .rf_base    (rf_base_r),
        .dest       (dest_r),
        .rls_op     (rls_op_r),
        .rows       (rows_r),
        .row        (row_r),
        .tdata      (enc_tdata),
        .tuser      (enc_tuser),
        .tlast      (enc_tlast)
    );

`ifdef MVM_SEQ_TIMEOUT_EN
    logic [TOW-1:0] to_cnt;

    // Watchdog on the result wait: held at zero outside WAIT so it is clear
    // on entry, then counts every WAIT cycle. Expiry is only a request; a
    // res_fire in the same cycle still completes the job normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TOW'(1);
        end
    end

    assign to_expired = (state == WAIT) && (to_cnt == '1);
`else
    assign to_expired = 1'b0;
`endif

    // State register. Reset is asynchronous so a partial stream is dropped
    // immediately and m_tvalid falls without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Descriptor latch, row counter and sticky error. The descriptor is
    // captured on accept so the job queue may move on immediately. A result
    // seen while still issuing means the tile released early, which is an
    // error for this job, including when it lines up with the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_base_r <= '0;
            accum_r   <= '0;
            dest_r    <= '0;
            rows_r    <= '0;
            row_r     <= '0;
            rls_op_r  <= 1'b0;
            rdc_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        rf_base_r <= job_rf_base;
                        accum_r   <= job_accum_addr;
                        dest_r    <= job_dest;
                        rows_r    <= job_rows;
                        rls_op_r  <= job_rls_op;
                        rdc_r     <= job_rdc;
                        row_r     <= '0;
                        err_r     <= (job_rows == '0);
                    end
                end
                ISSUE: begin
                    if (beat_fire) begin
                        row_r <= row_r + ROWW'(1);
                    end
                    if (res_fire) begin
                        err_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!res_fire && to_expired) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs. Beat contents are zeroed whenever m_tvalid is
    // low; while valid they come from latched registers and the row counter,
    // which only moves on a fire, so they hold steady through a stall.
    always_comb begin
        state_next = state;
        job_ready  = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tuser    = '0;
        m_tlast    = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        err        = 1'b0;

        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    state_next = (job_rows == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                m_tvalid = 1'b1;
                m_tdata  = enc_tdata;
                m_tuser  = enc_tuser;
                m_tlast  = enc_tlast;
                if (beat_fire && last_beat) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (res_fire || to_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                err        = err_r;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mvm_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mvm_inst_sequencer
// Scoreboard bench for mvm_inst_sequencer. Stimulus pushes the expected
// instruction words and completion errors into queues; a monitor on the
// falling clock edge pops and compares whenever a beat fires or done pulses.
// Build with MVM_SEQ_TIMEOUT_EN to exercise the watchdog (TOW=4).
// -----------------------------------------------------------------------------
module tb_mvm_inst_sequencer;

    localparam int DATAW   = 512;
    localparam int USERW   = 75;
    localparam int RFADDRW = 9;
    localparam int NODESW  = 9;
    localparam int ROWW    = 9;

    logic               clk;
    logic               rst_n;
    logic               job_valid;
    logic               job_ready;
    logic [RFADDRW-1:0] job_rf_base;
    logic [ROWW-1:0]    job_rows;
    logic [RFADDRW-1:0] job_accum_addr;
    logic [NODESW-1:0]  job_dest;
    logic               job_rls_op;
    logic               job_rdc;
    logic               m_tvalid;
    logic [DATAW-1:0]   m_tdata;
    logic [USERW-1:0]   m_tuser;
    logic               m_tlast;
    logic               m_tready;
    logic               res_fire;
    logic               busy;
    logic               done;
    logic               err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats_seen = 0;
    logic [31:0] exp_beats[$];
    logic        exp_done_err[$];
    logic        stall_pending = 1'b0;
    logic [31:0] stall_word;

    mvm_inst_sequencer #(
        .DATAW   (DATAW),
        .USERW   (USERW),
        .RFADDRW (RFADDRW),
        .NODESW  (NODESW),
        .ROWW    (ROWW)
`ifdef MVM_SEQ_TIMEOUT_EN
        ,
        .TOW     (4)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_rf_base    (job_rf_base),
        .job_rows       (job_rows),
        .job_accum_addr (job_accum_addr),
        .job_dest       (job_dest),
        .job_rls_op     (job_rls_op),
        .job_rdc        (job_rdc),
        .m_tvalid       (m_tvalid),
        .m_tdata        (m_tdata),
        .m_tuser        (m_tuser),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .res_fire       (res_fire),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference instruction word for row i of a job.
    function automatic logic [31:0] expWord(input int rows, input int i, input int base,
                                            input int accum, input int dest,
                                            input bit rls_op, input bit rdc);
        logic [31:0] w;
        w        = '0;
        w[0]     = rdc;
        w[1]     = (i != 0);
        w[2]     = (i == rows - 1);
        w[3]     = (i == rows - 1);
        w[12:4]  = 9'(accum);
        w[21:13] = 9'((base + i) % 512);
        w[30:22] = 9'(dest);
        w[31]    = rls_op;
        return w;
    endfunction

    // Monitor: scoreboard pops on every fired beat and every done pulse,
    // and checks that a stalled beat is held unchanged on the next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                checkOutput("stall_hold", {31'd0, m_tvalid, m_tdata[31:0]}, {31'd0, 1'b1, stall_word});
            end
            stall_pending = m_tvalid && !m_tready;
            stall_word    = m_tdata[31:0];

            if (m_tvalid && m_tready) begin
                beats_seen++;
                if (exp_beats.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(m_tdata[31:0]), 64'd0);
                end else begin
                    checkOutput("beat_tdata", 64'(m_tdata[31:0]), 64'(exp_beats.pop_front()));
                end
                checkOutput("beat_tlast", 64'(m_tlast), 64'd1);
                checkOutput("beat_tuser_zero", 64'(m_tuser == '0), 64'd1);
                checkOutput("beat_upper_zero", 64'(m_tdata[DATAW-1:32] == '0), 64'd1);
            end

            if (done) begin
                if (exp_done_err.size() == 0) begin
                    checkOutput("unexpected_done", 64'(done), 64'd0);
                end else begin
                    checkOutput("done_err", 64'(err), 64'(exp_done_err.pop_front()));
                end
            end
        end
    end

    // Presents a job, waits for accept, scrambles the inputs afterwards and
    // checks the one-cycle accept-to-first-beat latency.
    task automatic applyStimulus(input int rows, input int base, input int accum, input int dest,
                                 input bit rls_op, input bit rdc, input bit hand,
                                 input bit push_done, input bit exp_err);
        int t;
        if (!hand) begin
            for (int i = 0; i < rows; i++) begin
                exp_beats.push_back(expWord(rows, i, base, accum, dest, rls_op, rdc));
            end
        end
        if (push_done) begin
            exp_done_err.push_back(exp_err);
        end
        job_rows       = ROWW'(rows);
        job_rf_base    = RFADDRW'(base);
        job_accum_addr = RFADDRW'(accum);
        job_dest       = NODESW'(dest);
        job_rls_op     = rls_op;
        job_rdc        = rdc;
        job_valid      = 1'b1;
        t = 0;
        while (!job_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checkOutput("job_ready_before_accept", 64'(job_ready), 64'd1);
        @(posedge clk); #1;
        job_valid      = 1'b0;
        job_rows       = '1;
        job_rf_base    = ~job_rf_base;
        job_accum_addr = ~job_accum_addr;
        job_dest       = ~job_dest;
        job_rls_op     = ~job_rls_op;
        job_rdc        = ~job_rdc;
        checkOutput("accept_to_tvalid", 64'(m_tvalid), 64'(rows != 0));
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        checkOutput("job_ready_while_busy", 64'(job_ready), 64'd0);
    endtask

    // Runs until every expected beat has fired, optionally toggling tready.
    task automatic drainBeats(input int bound, input bit toggle);
        int t;
        t = 0;
        while (exp_beats.size() != 0 && t < bound) begin
            if (toggle) m_tready = ~m_tready;
            @(posedge clk); #1;
            t++;
        end
        checkOutput("beats_drained", 64'(exp_beats.size()), 64'd0);
    endtask

    task automatic pulseResult();
        res_fire = 1'b1;
        @(posedge clk); #1;
        res_fire = 1'b0;
    endtask

    // Waits for done (bounded), reports how many cycles it took, then steps
    // the FSM back to IDLE.
    task automatic waitDone(input int bound, output int cycles);
        cycles = 0;
        while (!done && cycles < bound) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("done_seen", 64'(done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Overall time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1, n_fail + 1);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int cyc;
        int b0;

        rst_n          = 1'b0;
        job_valid      = 1'b0;
        job_rf_base    = '0;
        job_rows       = '0;
        job_accum_addr = '0;
        job_dest       = '0;
        job_rls_op     = 1'b0;
        job_rdc        = 1'b0;
        m_tready       = 1'b0;
        res_fire       = 1'b0;
        applyReset();

        $display("[TB] reset state");
        checkOutput("rst_job_ready", 64'(job_ready), 64'd1);
        checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_tlast", 64'(m_tlast), 64'd0);
        checkOutput("rst_tdata_zero", 64'(m_tdata == '0), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);

        $display("[TB] single-row job");
        m_tready = 1'b1;
        exp_beats.push_back(32'h8000_200C);
        applyStimulus(1, 1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drainBeats(20, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("t1_wait_busy", 64'(busy), 64'd1);
        checkOutput("t1_wait_no_done", 64'(done), 64'd0);
        pulseResult();
        waitDone(10, cyc);
        checkOutput("t1_done_latency", 64'(cyc), 64'd0);

        $display("[TB] four rows with RF address wrap");
        exp_beats.push_back(32'h003F_C000);
        exp_beats.push_back(32'h003F_E002);
        exp_beats.push_back(32'h0000_0002);
        exp_beats.push_back(32'h0000_200E);
        applyStimulus(4, 510, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drainBeats(20, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        pulseResult();
        waitDone(10, cyc);

        $display("[TB] three rows with tready toggling");
        m_tready = 1'b0;
        b0 = beats_seen;
        applyStimulus(3, 5, 165, 307, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drainBeats(40, 1'b1);
        checkOutput("t3_fire_count", 64'(beats_seen - b0), 64'd3);
        m_tready = 1'b1;
        pulseResult();
        waitDone(10, cyc);

        $display("[TB] zero-row job");
        b0 = beats_seen;
        applyStimulus(0, 3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        waitDone(2, cyc);
        checkOutput("t4_no_beats", 64'(beats_seen - b0), 64'd0);

        $display("[TB] result during issue");
        m_tready = 1'b0;
        applyStimulus(3, 100, 7, 9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        pulseResult();
        m_tready = 1'b1;
        drainBeats(20, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        pulseResult();
        waitDone(10, cyc);

        $display("[TB] result on the last-beat cycle");
        m_tready = 1'b0;
        applyStimulus(1, 40, 2, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        res_fire = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        res_fire = 1'b0;
        checkOutput("t4c_beats_done", 64'(exp_beats.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t4c_still_waiting", 64'(busy && !done), 64'd1);
        pulseResult();
        waitDone(10, cyc);

        $display("[TB] reset mid-issue");
        applyStimulus(4, 20, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t5_two_beats_left", 64'(exp_beats.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_tvalid_async_drop", 64'(m_tvalid), 64'd0);
        checkOutput("t5_busy_cleared", 64'(busy), 64'd0);
        exp_beats.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2, 7, 11, 13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drainBeats(20, 1'b0);
        pulseResult();
        waitDone(10, cyc);

        $display("[TB] result wait watchdog");
`ifdef MVM_SEQ_TIMEOUT_EN
        applyStimulus(1, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drainBeats(20, 1'b0);
        waitDone(40, cyc);
        checkOutput("t6_timeout_window", 64'(cyc >= 14 && cyc <= 17), 64'd1);
`else
        applyStimulus(1, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drainBeats(20, 1'b0);
        repeat (40) begin @(posedge clk); #1; end
        checkOutput("t6_busy_holds", 64'(busy), 64'd1);
        checkOutput("t6_no_done", 64'(done), 64'd0);
        pulseResult();
        waitDone(10, cyc);
`endif

        repeat (3) begin @(posedge clk); #1; end
        checkOutput("end_beat_queue_empty", 64'(exp_beats.size()), 64'd0);
        checkOutput("end_done_queue_empty", 64'(exp_done_err.size()), 64'd0);
        checkOutput("end_idle", 64'(job_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
